// File: rtl/control_pkg.sv
// control_pkg
//   Constants shared by the instruction register and control logic:
//   opcode values for the jump/halt decode, bit positions inside the
//   flags vector, and the RUN/HALTED state encoding.
package control_pkg;

  // Opcodes that the instruction register itself needs to recognise.
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Bit positions inside the packed flags vector.
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_COUNT = 2;

  // Run state: once halted, only reset returns the block to RUN.
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ir_state_e;

endpackage

// File: rtl/flags_register.sv
// flags_register
//   Latches the ALU carry and the zero-detect of the ALU result when FI is
//   strobed while the machine is running. Frozen while halted.
// Ports:
//   clk_i          control clock, rising edge
//   rst_i          synchronous active-high reset
//   fi_i           flags-in strobe
//   run_i          1 while in RUN; gates fi_i
//   carry_i        ALU carry out
//   alu_result_i   ALU sum used for zero detect
//   carry_flag_o   latched carry
//   zero_flag_o    latched zero
module flags_register
  import control_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fi_i,
  input  logic                  run_i,
  input  logic                  carry_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic                  carry_flag_o,
  output logic                  zero_flag_o
);

  logic [FLAG_COUNT-1:0] flags_q;
  logic [FLAG_COUNT-1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (fi_i && run_i) begin
      flags_d[FLAG_CARRY] = carry_i;
      flags_d[FLAG_ZERO]  = (alu_result_i == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign carry_flag_o = flags_q[FLAG_CARRY];
  assign zero_flag_o  = flags_q[FLAG_ZERO];

endmodule

// File: rtl/instruction_register.sv
// instruction_register
//   Holds the fetched instruction and ALU flags for control_logic, splits
//   the instruction into opcode/operand, resolves conditional jumps and
//   provides a sticky halt state (left only through reset).
// Configuration macro:
//   IR_INSTR_COUNT_EN  when defined, instr_count counts II loads since reset
//                      (wrapping); otherwise instr_count is tied to 0.
// Ports:
//   control_clk   clock, rising edge          rst          sync reset, active high
//   bus_in        bus value                   II           load instruction
//   IO            drive operand onto bus      FI           load flags
//   carry_in      ALU carry                   alu_result   ALU sum (zero detect)
//   HLT           halt request
//   opcode        IR upper bits               operand      IR low nibble, zero-extended
//   operand_oe    bus drive enable            carry_flag / zero_flag  latched flags
//   jump_taken    jump resolved for opcode    opcode_valid  an instruction was loaded
//   halted        sticky halt                 instr_count  loads since reset
module instruction_register
  import control_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    control_clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   bus_in,
  input  logic                    II,
  input  logic                    IO,
  input  logic                    FI,
  input  logic                    carry_in,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    HLT,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0]   operand,
  output logic                    operand_oe,
  output logic                    carry_flag,
  output logic                    zero_flag,
  output logic                    jump_taken,
  output logic                    opcode_valid,
  output logic                    halted,
  output logic [DATA_WIDTH-1:0]   instr_count
);

  localparam int OPERAND_BITS = DATA_WIDTH - OPCODE_WIDTH;

  ir_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  valid_q, valid_d;
  logic                  run;
  logic                  load;

  // ---------------- state machine: register ----------------
  always_ff @(posedge control_clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- state machine: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && HLT) begin
      state_d = ST_HALTED;
    end
  end

  // ---------------- state machine: outputs ----------------
  always_comb begin
    halted     = (state_q == ST_HALTED);
    run        = (state_q == ST_RUN);
    operand_oe = IO & (state_q == ST_RUN);
  end

  // An II on the same edge as HLT still loads: the gate uses the current
  // state, not the next one.
  assign load = II & run;

  always_comb begin
    ir_d    = ir_q;
    valid_d = valid_q;
    if (load) begin
      ir_d    = bus_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge control_clk) begin
    if (rst) begin
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign opcode       = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand      = DATA_WIDTH'(ir_q[OPERAND_BITS-1:0]);
  assign opcode_valid = valid_q;

  flags_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_flags (
    .clk_i        (control_clk),
    .rst_i        (rst),
    .fi_i         (FI),
    .run_i        (run),
    .carry_i      (carry_in),
    .alu_result_i (alu_result),
    .carry_flag_o (carry_flag),
    .zero_flag_o  (zero_flag)
  );

  // Resolved from registered opcode and flags, so an FI on the same edge
  // only affects the decision from the following cycle.
  always_comb begin
    jump_taken = 1'b0;
    case (4'(opcode))
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = carry_flag;
      OP_JZ:   jump_taken = zero_flag;
      default: jump_taken = 1'b0;
    endcase
  end

`ifdef IR_INSTR_COUNT_EN
  logic [DATA_WIDTH-1:0] count_q, count_d;

  // Natural wrap at 2^DATA_WIDTH.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge control_clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instruction_register.sv
module tb_instruction_register;

  logic       clk = 1'b0;
  logic       rst, ii, io, fi, cin, hlt;
  logic [7:0] bus, alu;
  logic [3:0] opcode;
  logic [7:0] operand, instr_count;
  logic       operand_oe, carry_flag, zero_flag, jump_taken, opcode_valid, halted;

  always #5 clk = ~clk;

  instruction_register #(.DATA_WIDTH(8), .OPCODE_WIDTH(4)) dut (
    .control_clk (clk),
    .rst         (rst),
    .bus_in      (bus),
    .II          (ii),
    .IO          (io),
    .FI          (fi),
    .carry_in    (cin),
    .alu_result  (alu),
    .HLT         (hlt),
    .opcode      (opcode),
    .operand     (operand),
    .operand_oe  (operand_oe),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .jump_taken  (jump_taken),
    .opcode_valid(opcode_valid),
    .halted      (halted),
    .instr_count (instr_count)
  );

  typedef struct {
    logic       rst;
    logic [7:0] bus;
    logic       ii, io, fi, cin;
    logic [7:0] alu;
    logic       hlt;
    logic [3:0] op;
    logic [7:0] opnd;
    logic       oe, c, z, j, v, h;
    int         cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [7:0] m_ir;
  logic       m_c, m_z, m_halt, m_valid;
  int         m_cnt;

  function automatic int cexp(int n);
`ifdef IR_INSTR_COUNT_EN
    return n % 256;
`else
    return 0;
`endif
  endfunction

  function automatic logic m_jump(logic [7:0] ir, logic c, logic z);
    int op = int'(ir) / 16;
    if (op == 6) return 1'b1;
    if (op == 7) return c;
    if (op == 8) return z;
    return 1'b0;
  endfunction

  task automatic chk(string tag, string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [3:0] op, logic [7:0] opnd, logic oe,
                           logic c, logic z, logic j, logic v, logic h, int cnt);
    chk(tag, "opcode",       int'(opcode),       int'(op));
    chk(tag, "operand",      int'(operand),      int'(opnd));
    chk(tag, "operand_oe",   int'(operand_oe),   int'(oe));
    chk(tag, "carry_flag",   int'(carry_flag),   int'(c));
    chk(tag, "zero_flag",    int'(zero_flag),    int'(z));
    chk(tag, "jump_taken",   int'(jump_taken),   int'(j));
    chk(tag, "opcode_valid", int'(opcode_valid), int'(v));
    chk(tag, "halted",       int'(halted),       int'(h));
    chk(tag, "instr_count",  int'(instr_count),  cnt);
  endtask

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic step(logic r, logic [7:0] b, logic i_ii, logic i_io, logic i_fi,
                      logic i_c, logic [7:0] a, logic i_h);
    @(negedge clk);
    rst = r; bus = b; ii = i_ii; io = i_io; fi = i_fi; cin = i_c; alu = a; hlt = i_h;
    @(posedge clk);
    if (r) begin
      m_ir = 8'h00; m_c = 0; m_z = 0; m_halt = 0; m_valid = 0; m_cnt = 0;
    end else if (!m_halt) begin
      if (i_ii) begin
        m_ir = b; m_valid = 1; m_cnt = (m_cnt + 1) % 256;
      end
      if (i_fi) begin
        m_c = i_c; m_z = (a == 8'd0);
      end
      if (i_h) m_halt = 1;
    end
    #1;
  endtask

  task automatic check_model(string tag);
    check_all(tag, m_ir[7:4], {4'h0, m_ir[3:0]}, io & ~m_halt, m_c, m_z,
              m_jump(m_ir, m_c, m_z), m_valid, m_halt, cexp(m_cnt));
  endtask

  vec_t tbl[15];

  initial begin
    rst = 1; bus = 0; ii = 0; io = 0; fi = 0; cin = 0; alu = 0; hlt = 0;
    m_ir = 0; m_c = 0; m_z = 0; m_halt = 0; m_valid = 0; m_cnt = 0;

    //          rst bus   ii io fi c  alu   hlt  op    opnd  oe c  z  j  v  h  cnt
    tbl[0]  = '{1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 8'h2E, 1, 0, 0, 0, 8'h00, 0, 4'h2, 8'h0E, 0, 0, 0, 0, 1, 0, cexp(1)};
    tbl[3]  = '{0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 4'h2, 8'h0E, 1, 0, 0, 0, 1, 0, cexp(1)};
    tbl[4]  = '{0, 8'h00, 0, 0, 1, 1, 8'h00, 0, 4'h2, 8'h0E, 0, 1, 1, 0, 1, 0, cexp(1)};
    tbl[5]  = '{0, 8'h73, 1, 0, 0, 0, 8'h00, 0, 4'h7, 8'h03, 0, 1, 1, 1, 1, 0, cexp(2)};
    tbl[6]  = '{0, 8'h00, 0, 0, 1, 0, 8'h05, 0, 4'h7, 8'h03, 0, 0, 0, 0, 1, 0, cexp(2)};
    tbl[7]  = '{0, 8'h83, 1, 0, 0, 0, 8'h00, 0, 4'h8, 8'h03, 0, 0, 0, 0, 1, 0, cexp(3)};
    tbl[8]  = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 4'h8, 8'h03, 0, 0, 1, 1, 1, 0, cexp(3)};
    tbl[9]  = '{0, 8'hF0, 1, 0, 0, 0, 8'h00, 1, 4'hF, 8'h00, 0, 0, 1, 0, 1, 1, cexp(4)};
    tbl[10] = '{0, 8'h11, 1, 1, 1, 1, 8'h07, 0, 4'hF, 8'h00, 0, 0, 1, 0, 1, 1, cexp(4)};
    tbl[11] = '{1, 8'h55, 1, 0, 1, 1, 8'h00, 1, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 8'h60, 1, 0, 0, 0, 8'h00, 0, 4'h6, 8'h00, 0, 0, 0, 1, 1, 0, cexp(1)};
    tbl[13] = '{0, 8'h70, 1, 0, 1, 1, 8'h00, 0, 4'h7, 8'h00, 0, 1, 1, 1, 1, 0, cexp(2)};
    tbl[14] = '{0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 4'h7, 8'h00, 0, 1, 1, 1, 1, 1, cexp(2)};

    for (int k = 0; k < 15; k++) begin
      step(tbl[k].rst, tbl[k].bus, tbl[k].ii, tbl[k].io, tbl[k].fi, tbl[k].cin,
           tbl[k].alu, tbl[k].hlt);
      check_all($sformatf("vec%0d", k), tbl[k].op, tbl[k].opnd, tbl[k].oe, tbl[k].c,
                tbl[k].z, tbl[k].j, tbl[k].v, tbl[k].h, tbl[k].cnt);
      $display("vec%0d: op=%h operand=%h oe=%b c=%b z=%b j=%b v=%b h=%b cnt=%0d", k,
               opcode, operand, operand_oe, carry_flag, zero_flag, jump_taken,
               opcode_valid, halted, instr_count);
    end

    // 256 consecutive loads: count wraps back to zero.
    step(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 256; k++) begin
      step(0, 8'($urandom_range(0, 239)), 1, 0, 0, 0, 8'h00, 0);
      check_model($sformatf("wrap%0d", k));
    end
    chk("wrap_end", "instr_count", int'(instr_count), 0);
    $display("wrap: after 256 loads instr_count=%0d", instr_count);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) < 3, 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
           $urandom_range(0, 99) < 4);
      check_model($sformatf("rnd%0d", k));
      $display("rnd%0d: op=%h c=%b z=%b j=%b h=%b cnt=%0d", k, opcode, carry_flag,
               zero_flag, jump_taken, halted, instr_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
